// File: rtl/frame_ram_scheduler.sv
// frame_ram_scheduler
// Arbitrates the single port of the 80x60 frame-buffer RAM between three users:
// a clear sequencer, the display read port and the pixel writer.
// Display reads always win. A pixel write is a read-modify-write of one word.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   clear_req           request a full-RAM clear (pulse or level)
//   clear_busy          high while the clear sequencer owns the RAM
//   rd_req/rd_addr      display read request and word address
//   rd_gnt              read issued this cycle (combinational)
//   rd_valid/rd_data    read data, one cycle after rd_gnt
//   wr_req/wr_addr/wr_bit/wr_val
//                       pixel write request, held by the writer until wr_done
//   wr_done             one-cycle pulse when the write has been committed
//   ram_*               RAM macro interface (ram_q is the registered RAM output)
module frame_ram_scheduler #(
  parameter int RAMLENGTH      = 800,
  parameter int DATA_WIDTH     = 6,
  parameter int ADDR_WIDTH     = 10,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  output logic                  clear_busy,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [2:0]            wr_bit,
  input  logic                  wr_val,
  output logic                  wr_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  output logic                  ram_memenable,
  output logic [ADDR_WIDTH-1:0] ram_resetcnt,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RMW_CAP = 2'd2,
    ST_RMW_WR  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(RAMLENGTH - 1);
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  state_t                  state_r;
  state_t                  state_s;
  logic [ADDR_WIDTH-1:0]   clr_cnt_r;
  logic                    clr_pend_r;
  logic                    rd_valid_r;
  logic                    wr_done_r;
  logic [DATA_WIDTH-1:0]   word_r;
  logic [ADDR_WIDTH-1:0]   wr_addr_r;
  logic [2:0]              wr_bit_r;
  logic                    wr_val_r;
  logic                    accept_wr_s;
  logic                    commit_s;
  logic                    enter_clear_s;

  // Replace one pixel of a word; an out-of-range pixel index leaves the word unchanged.
  function automatic logic [DATA_WIDTH-1:0] merge_pixel(
    input logic [DATA_WIDTH-1:0] word,
    input logic [2:0]            pix,
    input logic                  val
  );
    logic [DATA_WIDTH-1:0] res;
    res = word;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (int'(pix) == i) begin
        res[i] = val;
      end else begin
        res[i] = word[i];
      end
    end
    return res;
  endfunction

  // Next-state logic and combinational RAM/grant outputs.
  always_comb begin
    state_s       = state_r;
    rd_gnt        = 1'b0;
    ram_addr      = rd_addr;
    ram_data      = word_r;
    ram_we        = 1'b0;
    ram_memenable = 1'b1;
    ram_resetcnt  = clr_cnt_r;
    accept_wr_s   = 1'b0;
    commit_s      = 1'b0;
    enter_clear_s = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        // RAM fills the word at ram_resetcnt with all-ones while memenable is low.
        ram_memenable = 1'b0;
        if (clr_cnt_r == CLR_LAST) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        if (clr_pend_r) begin
          state_s       = ST_CLEAR;
          enter_clear_s = 1'b1;
        end else if (rd_req) begin
          rd_gnt = 1'b1;
        end else if (wr_req && !wr_done_r) begin
          // The writer still holds wr_req during the wr_done cycle; do not
          // accept that stale request a second time.
          ram_addr    = wr_addr;
          accept_wr_s = 1'b1;
          state_s     = ST_RMW_CAP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RMW_CAP: begin
        // ram_q now holds the word read in IDLE, so a new read can be issued
        // without disturbing the capture.
        rd_gnt  = rd_req;
        state_s = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        if (rd_req) begin
          rd_gnt = 1'b1;
        end else begin
          ram_we   = 1'b1;
          ram_addr = wr_addr_r;
          commit_s = 1'b1;
          state_s  = ST_IDLE;
        end
      end
      default: begin
        state_s = RESET_STATE;
      end
    endcase
  end

  // State, clear counter, pending-clear flag and read/write handshake registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= RESET_STATE;
      clr_cnt_r  <= {ADDR_WIDTH{1'b0}};
      clr_pend_r <= 1'b0;
      rd_valid_r <= 1'b0;
      wr_done_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      rd_valid_r <= rd_gnt;
      wr_done_r  <= commit_s;
      if ((state_r == ST_CLEAR) && (clr_cnt_r != CLR_LAST)) begin
        clr_cnt_r <= clr_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        clr_cnt_r <= {ADDR_WIDTH{1'b0}};
      end
      if (enter_clear_s) begin
        clr_pend_r <= 1'b0;
      end else if (clear_req) begin
        clr_pend_r <= 1'b1;
      end else begin
        clr_pend_r <= clr_pend_r;
      end
    end
  end

  // Latched write request and the merged word for the write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_r    <= {DATA_WIDTH{1'b0}};
      wr_addr_r <= {ADDR_WIDTH{1'b0}};
      wr_bit_r  <= 3'd0;
      wr_val_r  <= 1'b0;
    end else begin
      if (accept_wr_s) begin
        wr_addr_r <= wr_addr;
        wr_bit_r  <= wr_bit;
        wr_val_r  <= wr_val;
      end else begin
        wr_addr_r <= wr_addr_r;
        wr_bit_r  <= wr_bit_r;
        wr_val_r  <= wr_val_r;
      end
      if (state_r == ST_RMW_CAP) begin
        word_r <= merge_pixel(ram_q, wr_bit_r, wr_val_r);
      end else begin
        word_r <= word_r;
      end
    end
  end

  assign clear_busy = (state_r == ST_CLEAR);
  assign rd_valid   = rd_valid_r;
  assign wr_done    = wr_done_r;
  assign rd_data    = ram_q;

endmodule
